delay_line: RTL and testbench

- Parametrised multi-bit, valid-tagged delay line; successor to the single-bit fixed-depth delay primitive.
- Delays a WIDTH-bit payload plus valid flag by a runtime-selectable 1..MAX_DEPTH cycles, with stall (en) and flush support.
- Used in the npc pipeline for aligning side-band signals (trace, difftest tags, commit info) with multi-cycle units.

---
 rtl/delay_pkg.sv | 22 ++
 rtl/delay_stage.sv | 37 +++
 rtl/delay_line.sv | 194 +++++++++++++++++++
 tb/tb_delay_line.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// delay_line shared types and constants.
// Parity helper is used only when DELAY_LINE_PARITY_EN is defined.
package delay_pkg;

  localparam int DL_WIDTH     = 32;
  localparam int DL_MAX_DEPTH = 8;
  localparam int DL_PAR_MAXW  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dl_state_e;

  // Even-parity bit: data plus this bit carries an even count of ones.
  function automatic logic even_par(
    input logic [DL_PAR_MAXW-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage: one {valid, data} register of the delay line.
// Flush clears only the valid; data moves only on advance.
module delay_stage
  import delay_pkg::*;
#(
  parameter int DW = DL_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  // Stage register: flush beats en, en loads the upstream beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/delay_line.sv
// delay_line: valid-tagged delay of 1..MAX_DEPTH cycles with stall/flush.
// Optional per-stage parity with par_err output: DELAY_LINE_PARITY_EN.
module delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH     = DL_WIDTH,
  parameter int MAX_DEPTH = DL_MAX_DEPTH,
  parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] dly_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] occupancy,
  output logic             busy,
`ifdef DELAY_LINE_PARITY_EN
  output logic             par_err,
`endif
  output logic             cfg_err
);

`ifdef DELAY_LINE_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int DW = WIDTH + PW;
  localparam logic [SEL_W-1:0] MAXD = SEL_W'(MAX_DEPTH);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  dl_state_e        state_q, state_d;
  logic [SEL_W-1:0] dly_q, dly_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] occ_q, occ_d;
  logic             cfg_err_q, cfg_err_d;

  logic                 legal;
  logic                 chg;
  logic                 acc;
  logic                 leave;
  logic [MAX_DEPTH-1:0] sv;
  logic [MAX_DEPTH-1:0] svin;
  logic [DW-1:0]        sd   [MAX_DEPTH];
  logic [DW-1:0]        sdin [MAX_DEPTH];
  logic [DW-1:0]        din0;
  logic [DW-1:0]        out_word;

  assign legal = (dly_sel != '0) && (dly_sel <= MAXD);
  assign chg   = legal && (dly_sel != dly_q);
  assign acc   = en && in_valid && !flush && (state_q != DRAIN);
  assign leave = en && out_valid && !flush;

`ifdef DELAY_LINE_PARITY_EN
  assign din0 = {even_par(DL_PAR_MAXW'(in_data)), in_data};
`else
  assign din0 = in_data;
`endif

  // Beats past the active tap lose their valid so a later, longer
  // delay cannot resurrect them.
  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign svin[i] = in_valid && (state_q != DRAIN);
      assign sdin[i] = din0;
    end else begin : g_body
      assign svin[i] = sv[i-1] && (SEL_W'(i) < dly_q);
      assign sdin[i] = sd[i-1];
    end

    delay_stage #(
      .DW(DW)
    ) u_stg (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .flush   (flush),
      .valid_i (svin[i]),
      .data_i  (sdin[i]),
      .valid_o (sv[i]),
      .data_o  (sd[i])
    );
  end

  // Control state: FSM, active/pending delay, count, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dly_q     <= MAXD;
      pend_q    <= MAXD;
      occ_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      pend_q    <= pend_d;
      occ_q     <= occ_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next state: delay changes only land while the line is empty.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    pend_d    = pend_q;
    occ_d     = occ_q;
    cfg_err_d = cfg_err_q | ~legal;

    if (flush) begin
      occ_d = '0;
    end else if (acc && !leave) begin
      occ_d = occ_q + ONE;
    end else if (!acc && leave) begin
      occ_d = occ_q - ONE;
    end

    if (flush) begin
      state_d = IDLE;
      if (state_q == DRAIN) begin
        dly_d = pend_q;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (chg) begin
            dly_d = dly_sel;
          end
          if (acc) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (occ_d == '0) begin
            state_d = IDLE;
          end else if (chg) begin
            pend_d  = dly_sel;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (legal) begin
            pend_d = dly_sel;
          end
          if (occ_d == '0) begin
            dly_d   = pend_d;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: tap at stage dly_q-1, plus derived status.
  always_comb begin
    out_valid = 1'b0;
    out_word  = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (SEL_W'(i + 1) == dly_q) begin
        out_valid = sv[i];
        out_word  = sd[i];
      end
    end
  end

  assign out_data  = out_word[WIDTH-1:0];
  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);
  assign cfg_err   = cfg_err_q;

`ifdef DELAY_LINE_PARITY_EN
  logic par_err_q;
  logic par_bad;

  assign par_bad = even_par(DL_PAR_MAXW'(out_data)) != out_word[DW-1];

  // Parity flag: one pulse as a corrupted beat leaves the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= out_valid && en && !flush && par_bad;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=32, MAX_DEPTH=8).
// Each task drives one scenario and checks expected values inline.
module tb_delay_line;
  import delay_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [3:0]  dly_sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  occupancy;
  logic        busy;
  logic        cfg_err;
`ifdef DELAY_LINE_PARITY_EN
  logic        par_err;
`endif

  int vec = 0;
  int err = 0;

  delay_line #(
    .WIDTH     (32),
    .MAX_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .dly_sel   (dly_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .busy      (busy),
`ifdef DELAY_LINE_PARITY_EN
    .par_err   (par_err),
`endif
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    flush    = 1'b0;
    dly_sel  = 4'd3;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) tick();
    vec++;
    if (out_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_ov got %b want 0", out_valid);
    end
    vec++;
    if (occupancy !== 4'd0 || busy !== 1'b0) begin
      err++;
      $display("FAIL reset_occ got %0d/%b want 0/0", occupancy, busy);
    end
    vec++;
    if (cfg_err !== 1'b0) begin
      err++;
      $display("FAIL reset_cfg got %b want 0", cfg_err);
    end
    rst_n = 1'b1;
    tick();
    vec++;
    if (out_valid !== 1'b0) begin
      err++;
      $display("FAIL rel_ov got %b want 0", out_valid);
    end
  endtask

  task automatic test_single();
    logic       eov;
    logic [3:0] eocc;
    dly_sel = 4'd3;
    for (int e = 0; e < 4; e++) begin
      in_valid = (e == 0);
      in_data  = (e == 0) ? 32'hDEADBEEF : 32'h0;
      tick();
      eov  = (e == 2);
      eocc = (e < 3) ? 4'd1 : 4'd0;
      vec++;
      if (out_valid !== eov) begin
        err++;
        $display("FAIL single_ov e=%0d got %b want %b", e, out_valid, eov);
      end
      if (eov) begin
        vec++;
        if (out_data !== 32'hDEADBEEF) begin
          err++;
          $display("FAIL single_data got %h want deadbeef", out_data);
        end
      end
      vec++;
      if (occupancy !== eocc) begin
        err++;
        $display("FAIL single_occ e=%0d got %0d want %0d", e, occupancy, eocc);
      end
    end
    vec++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL single_busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic        eov;
    logic [31:0] ed;
    logic [3:0]  eocc;
    dly_sel = 4'd8;
    for (int e = 0; e < 16; e++) begin
      in_valid = (e < 8);
      in_data  = 32'(e + 1);
      tick();
      eov  = (e >= 7) && (e <= 14);
      ed   = 32'(e - 6);
      eocc = (e <= 7) ? 4'(e + 1) : 4'(15 - e);
      vec++;
      if (out_valid !== eov) begin
        err++;
        $display("FAIL b2b_ov e=%0d got %b want %b", e, out_valid, eov);
      end
      if (eov) begin
        vec++;
        if (out_data !== ed) begin
          err++;
          $display("FAIL b2b_data e=%0d got %0d want %0d", e, out_data, ed);
        end
      end
      vec++;
      if (occupancy !== eocc || busy !== (eocc != 4'd0)) begin
        err++;
        $display("FAIL b2b_occ e=%0d got %0d/%b want %0d", e, occupancy, busy, eocc);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0]  en_p  = 8'b1111_0001;
    logic [7:0]  iv_p  = 8'b0011_0001;
    logic [7:0]  ov_p  = 8'b0111_0000;
    logic [31:0] d_t   [8] = '{32'hA, 0, 0, 0, 32'hB, 32'hC, 0, 0};
    logic [31:0] od_t  [8] = '{0, 0, 0, 0, 32'hA, 32'hB, 32'hC, 0};
    int          occ_t [8] = '{1, 1, 1, 1, 2, 2, 1, 0};
    dly_sel = 4'd2;
    for (int c = 0; c < 8; c++) begin
      en       = en_p[c];
      in_valid = iv_p[c];
      in_data  = d_t[c];
      tick();
      vec++;
      if (out_valid !== ov_p[c]) begin
        err++;
        $display("FAIL stall_ov c=%0d got %b want %b", c, out_valid, ov_p[c]);
      end
      if (ov_p[c]) begin
        vec++;
        if (out_data !== od_t[c]) begin
          err++;
          $display("FAIL stall_data c=%0d got %h want %h", c, out_data, od_t[c]);
        end
      end
      vec++;
      if (occupancy !== 4'(occ_t[c])) begin
        err++;
        $display("FAIL stall_occ c=%0d got %0d want %0d", c, occupancy, occ_t[c]);
      end
    end
    en       = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_dly_change();
    logic [9:0]  iv_p  = 10'b00_0001_1011;
    logic [9:0]  ov_p  = 10'b01_0000_0110;
    logic [3:0]  sel_t [10] = '{2, 2, 5, 5, 5, 5, 5, 5, 5, 5};
    logic [31:0] d_t   [10] = '{32'hA0, 32'hA1, 0, 32'hBAD, 32'hA5, 0, 0, 0, 0, 0};
    logic [31:0] od_t  [10] = '{0, 32'hA0, 32'hA1, 0, 0, 0, 0, 0, 32'hA5, 0};
    int          occ_t [10] = '{1, 2, 1, 0, 1, 1, 1, 1, 1, 0};
    for (int c = 0; c < 10; c++) begin
      dly_sel  = sel_t[c];
      in_valid = iv_p[c];
      in_data  = d_t[c];
      tick();
      vec++;
      if (out_valid !== ov_p[c]) begin
        err++;
        $display("FAIL chg_ov c=%0d got %b want %b", c, out_valid, ov_p[c]);
      end
      if (ov_p[c]) begin
        vec++;
        if (out_data !== od_t[c]) begin
          err++;
          $display("FAIL chg_data c=%0d got %h want %h", c, out_data, od_t[c]);
        end
      end
      vec++;
      if (occupancy !== 4'(occ_t[c])) begin
        err++;
        $display("FAIL chg_occ c=%0d got %0d want %0d", c, occupancy, occ_t[c]);
      end
      if (c == 2) begin
        vec++;
        if (dut.state_q !== DRAIN) begin
          err++;
          $display("FAIL chg_state got %0d want DRAIN", dut.state_q);
        end
      end
      if (c == 3) begin
        vec++;
        if (dut.state_q !== IDLE) begin
          err++;
          $display("FAIL chg_idle got %0d want IDLE", dut.state_q);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    dly_sel = 4'd5;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hF0 + 32'(c);
      tick();
    end
    vec++;
    if (occupancy !== 4'd4) begin
      err++;
      $display("FAIL flush_pre got %0d want 4", occupancy);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hF4;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    vec++;
    if (occupancy !== 4'd0 || busy !== 1'b0) begin
      err++;
      $display("FAIL flush_occ got %0d/%b want 0/0", occupancy, busy);
    end
    for (int c = 0; c < 8; c++) begin
      vec++;
      if (out_valid !== 1'b0) begin
        err++;
        $display("FAIL flush_ov c=%0d got %b want 0", c, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_cfg_err();
    logic eov;
    vec++;
    if (cfg_err !== 1'b0) begin
      err++;
      $display("FAIL cfg_pre got %b want 0", cfg_err);
    end
    dly_sel = 4'd0;
    tick();
    vec++;
    if (cfg_err !== 1'b1) begin
      err++;
      $display("FAIL cfg_zero got %b want 1", cfg_err);
    end
    dly_sel = 4'd9;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0);
      in_data  = 32'h5A5A;
      tick();
      eov = (c == 4);
      vec++;
      if (out_valid !== eov) begin
        err++;
        $display("FAIL cfg_lat c=%0d got %b want %b", c, out_valid, eov);
      end
    end
    in_valid = 1'b0;
    dly_sel  = 4'd5;
    tick();
    vec++;
    if (cfg_err !== 1'b1) begin
      err++;
      $display("FAIL cfg_sticky got %b want 1", cfg_err);
    end
  endtask

`ifdef DELAY_LINE_PARITY_EN
  task automatic test_parity();
    logic epe;
    dly_sel  = 4'd5;
    in_valid = 1'b1;
    in_data  = 32'h1;
    tick();
    in_valid = 1'b0;
    force dut.g_stg[0].u_stg.data_q = {1'b0, 32'h1};
    tick();
    release dut.g_stg[0].u_stg.data_q;
    for (int c = 2; c < 7; c++) begin
      tick();
      epe = (c == 5);
      vec++;
      if (par_err !== epe) begin
        err++;
        $display("FAIL par_err c=%0d got %b want %b", c, par_err, epe);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_dly_change();
    test_flush();
    test_cfg_err();
`ifdef DELAY_LINE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
